// File: rtl/kiwi_npu_pkg.sv
// Shared types and arithmetic helpers for the sequential NPU layer.
package kiwi_npu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Working width for the rounding/saturation helper; wide enough for any
    // practical accumulator so one function serves every parameterisation.
    localparam int SAT_W = 64;

    // Products need 2*dw bits; summing n of them grows by clog2(n); one extra
    // bit absorbs the bias term.
    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n) + 1;
    endfunction

    // Rescale a biased accumulator back to the Q format (floor), apply the
    // optional ReLU, then clamp to the signed dw-bit range.
    function automatic logic signed [SAT_W-1:0] sat_round(
        input logic signed [SAT_W-1:0] acc,
        input int                      frac,
        input int                      dw,
        input bit                      relu
    );
        logic signed [SAT_W-1:0] r;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        r  = acc >>> frac;
        if (relu && r < 0) r = '0;
        hi = (SAT_W'(1) <<< (dw - 1)) - 1;
        lo = -hi - 1;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/kiwi_seq_layer_if.sv
// Handshake and data bus of one sequential fully-connected layer.
interface kiwi_seq_layer_if #(
    parameter int IN_N       = 4,
    parameter int OUT_N      = 4,
    parameter int DATA_WIDTH = 8
);
    logic                               in_valid;
    logic                               in_ready;
    logic [IN_N*DATA_WIDTH-1:0]         in_vec;
    logic [OUT_N*IN_N*DATA_WIDTH-1:0]   weights;
    logic [OUT_N*DATA_WIDTH-1:0]        biases;
    logic                               out_valid;
    logic                               out_ready;
    logic [OUT_N*DATA_WIDTH-1:0]        out_vec;
    logic                               busy;

    modport master (
        output in_valid, in_vec, weights, biases, out_ready,
        input  in_ready, out_valid, out_vec, busy
    );

    modport slave (
        input  in_valid, in_vec, weights, biases, out_ready,
        output in_ready, out_valid, out_vec, busy
    );
endinterface

// File: rtl/kiwi_mac_lane.sv
// One shared MAC lane: signed multiply-accumulate plus the biased,
// rescaled, saturated result presented combinationally for the write cycle.
module kiwi_mac_lane
    import kiwi_npu_pkg::*;
#(
    parameter int DW        = 8,
    parameter int ACC_W     = 19,
    parameter int FRAC_BITS = 0,
    parameter int RELU_EN   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] w,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] res
);
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [2*DW-1:0]  prod;

    assign prod     = a * w;
    // Bias is in the same Q format as the inputs; the product carries twice
    // the fractional bits, so the bias is aligned before adding.
    assign bias_ext = ACC_W'(b) <<< FRAC_BITS;
    assign res      = DW'(sat_round(SAT_W'(acc + bias_ext), FRAC_BITS, DW, RELU_EN != 0));

    // Accumulator: clear wins over accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= acc + ACC_W'(prod);
    end
endmodule

// File: rtl/kiwi_seq_layer.sv
// Time-multiplexed fully-connected layer: LANES MAC lanes walk GROUPS output
// groups, IN_N MAC cycles plus one write cycle per group.
module kiwi_seq_layer
    import kiwi_npu_pkg::*;
#(
    parameter int IN_N       = 4,
    parameter int OUT_N      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 0,
    parameter int LANES      = 1,
    parameter int RELU_EN    = 1
) (
    input  logic            clk,
    input  logic            rst,
    kiwi_seq_layer_if.slave bus
);
    localparam int DW     = DATA_WIDTH;
    localparam int GROUPS = (OUT_N + LANES - 1) / LANES;
    localparam int ACC_W  = acc_width(DW, IN_N);
    localparam int IDX_W  = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    seq_state_e state, state_nx;

    logic [IDX_W-1:0] idx;
    logic [GRP_W-1:0] grp;
    logic             wr_ph;     // BUSY sub-phase: 0 = MAC, 1 = WRITE
    logic             accept, mac_en, lane_clr, wr_en;
    logic             last_idx, last_grp;

    logic [IN_N-1:0][DW-1:0]            in_q;
    logic [OUT_N-1:0][DW-1:0]           out_q;
    logic [OUT_N-1:0][IN_N-1:0][DW-1:0] w_arr;
    logic [OUT_N-1:0][DW-1:0]           b_arr;
    logic [LANES-1:0][DW-1:0]           lane_w, lane_b, lane_r;

    assign w_arr    = bus.weights;
    assign b_arr    = bus.biases;
    assign last_idx = (idx == IDX_W'(IN_N - 1));
    assign last_grp = (grp == GRP_W'(GROUPS - 1));

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == BUSY);
    assign bus.out_vec   = out_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and per-cycle datapath controls.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        mac_en   = 1'b0;
        lane_clr = 1'b0;
        wr_en    = 1'b0;
        case (state)
            IDLE: if (bus.in_valid) begin
                accept   = 1'b1;
                lane_clr = 1'b1;
                state_nx = BUSY;
            end
            BUSY: if (wr_ph) begin
                wr_en    = 1'b1;
                lane_clr = 1'b1;
                if (last_grp) state_nx = DONE;
            end else begin
                mac_en = 1'b1;
            end
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Input capture and grp/idx sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q  <= '0;
            idx   <= '0;
            grp   <= '0;
            wr_ph <= 1'b0;
        end else if (accept) begin
            in_q  <= bus.in_vec;
            idx   <= '0;
            grp   <= '0;
            wr_ph <= 1'b0;
        end else if (mac_en) begin
            if (last_idx) wr_ph <= 1'b1;
            else          idx   <= idx + 1'b1;
        end else if (wr_en) begin
            wr_ph <= 1'b0;
            idx   <= '0;
            grp   <= last_grp ? '0 : grp + 1'b1;
        end
    end

    // Result register: output o belongs to lane o%LANES of group o/LANES, so
    // lanes past OUT_N in the last group have no destination at all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else if (wr_en) begin
            for (int o = 0; o < OUT_N; o++) begin
                if (grp == GRP_W'(o / LANES)) out_q[o] <= lane_r[o % LANES];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [GROUPS-1:0][DW-1:0] w_col, b_col;

        // Per-group operand candidates; rows past OUT_N feed zeros.
        for (genvar g = 0; g < GROUPS; g++) begin : g_grp
            if (g * LANES + l < OUT_N) begin : g_on
                assign w_col[g] = w_arr[g*LANES+l][idx];
                assign b_col[g] = b_arr[g*LANES+l];
            end else begin : g_off
                assign w_col[g] = '0;
                assign b_col[g] = '0;
            end
        end

        assign lane_w[l] = w_col[grp];
        assign lane_b[l] = b_col[grp];

        kiwi_mac_lane #(
            .DW       (DW),
            .ACC_W    (ACC_W),
            .FRAC_BITS(FRAC_BITS),
            .RELU_EN  (RELU_EN)
        ) u_lane (
            .clk(clk),
            .rst(rst),
            .clr(lane_clr),
            .en (mac_en),
            .a  (in_q[idx]),
            .w  (lane_w[l]),
            .b  (lane_b[l]),
            .res(lane_r[l])
        );
    end
endmodule
